// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared constants and state encoding for the frame link arbiter
package link_pkg;

  localparam logic [7:0] LINK_HEADER = 8'hCA;
  localparam int LINK_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_B1,
    ST_B2,
    ST_CLOSE,
    ST_GAP
  } link_state_t;

endpackage

// File: rtl/frame_link_arbiter_if.sv
// rtl/frame_link_arbiter_if.sv - requester and frame link signal bundle
interface frame_link_arbiter_if
  import link_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]             req;
  logic [LINK_WORD_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]             gnt;
  logic                         done;
  logic                         done_err;
  logic                         busy;
  logic                         link_cs;
  logic [7:0]                   link_d;
  logic                         link_ack;
  logic                         link_err;

  modport master (
    input  req, req_data, link_ack, link_err,
    output gnt, done, done_err, busy, link_cs, link_d
  );

  modport slave (
    output req, req_data, link_ack, link_err,
    input  gnt, done, done_err, busy, link_cs, link_d
  );

endinterface

// File: rtl/frame_link_arbiter_rr_arbiter.sv
// rtl/frame_link_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  always_comb begin
    pick = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (pick == '0 && req[idx[IW-1:0]]) begin
        pick[idx[IW-1:0]] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/frame_link_arbiter.sv
// rtl/frame_link_arbiter.sv - round-robin arbiter driving a three-byte frame link with header retry
module frame_link_arbiter
  import link_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 2
) (
  input logic                  clk,
  input logic                  rst,
  frame_link_arbiter_if.master bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  link_state_t            state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d, ptr_q, ptr_d, pick_idx, next_ptr;
  logic [2:0]             retry_q, retry_d;
  logic [LINK_WORD_W-1:0] word_q, word_d, pick_word;
  logic [N_REQ-1:0]       gnt_q, gnt_d, pick;
  logic                   any_req;
  logic                   done_q, done_d, done_err_q, done_err_d, busy_q, busy_d;
  logic                   cs_q, cs_d;
  logic [7:0]             d_q, d_d;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any_req)
  );

  assign next_ptr = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);

  always_comb begin
    pick_idx  = '0;
    pick_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        pick_idx  = IW'(i);
        pick_word = bus.req_data[LINK_WORD_W*i +: LINK_WORD_W];
      end
    end
  end

  // Next state and the output values that state will present, registered together.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    retry_d    = retry_q;
    word_d     = word_q;
    gnt_d      = gnt_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_HDR;
          idx_d   = pick_idx;
          word_d  = pick_word;
          gnt_d   = pick;
          retry_d = '0;
        end
      end
      ST_HDR: state_d = ST_B1;
      ST_B1: begin
        if (bus.link_err) begin
          state_d = ST_GAP;
          // The final failed attempt reports during GAP while gnt is still high.
          if (retry_q >= 3'(MAX_RETRY)) begin
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end
        end else begin
          state_d = ST_B2;
        end
      end
      ST_B2: begin
        state_d = ST_CLOSE;
        done_d  = 1'b1;
      end
      ST_CLOSE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        ptr_d   = next_ptr;
      end
      ST_GAP: begin
        if (retry_q < 3'(MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    cs_d   = !(state_d inside {ST_HDR, ST_B1, ST_B2, ST_CLOSE});
    case (state_d)
      ST_HDR:  d_d = LINK_HEADER;
      ST_B1:   d_d = word_d[15:8];
      ST_B2:   d_d = word_d[7:0];
      default: d_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      retry_q    <= '0;
      word_q     <= '0;
      gnt_q      <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      d_q        <= 8'h00;
    end else begin
      assert (!(state_q == ST_B1 && !bus.link_err && bus.link_ack));
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      retry_q    <= retry_d;
      word_q     <= word_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      d_q        <= d_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.done_err = done_err_q;
  assign bus.busy     = busy_q;
  assign bus.link_cs  = cs_q;
  assign bus.link_d   = d_q;

endmodule
